conv_mac_relu_acc: RTL

- Downstream stage of the signed 14s x 10s product multiplier in the conv layer datapath; consumes the 24-bit signed products one per cycle.
- Accumulates TAPS products per output pixel, starting from a bias, using saturating arithmetic.
- Rescales by the weight fraction bits with round-half-up, applies ReLU, clamps to the 14-bit activation format, and presents the result on a single-entry valid/ready output register.

---
 rtl/conv_mac_relu_acc_if.sv | 26 ++
 rtl/conv_mac_relu_acc.sv | 115 +++++++++++
 2 files changed

// File: rtl/conv_mac_relu_acc_if.sv
// Product-in / activation-out handshake bundle between the multiplier,
// the MAC/ReLU accumulator and the downstream activation consumer.
`timescale 1ns/1ps
interface conv_mac_relu_acc_if #(
  parameter int PROD_WIDTH = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 14
);
  logic [ACC_WIDTH-1:0]  bias_din;
  logic [PROD_WIDTH-1:0] prod_din;
  logic                  prod_valid;
  logic                  prod_ready;
  logic [OUT_WIDTH-1:0]  out_dout;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output bias_din, prod_din, prod_valid, out_ready,
    input  prod_ready, out_dout, out_valid
  );

  modport slave (
    input  bias_din, prod_din, prod_valid, out_ready,
    output prod_ready, out_dout, out_valid
  );
endinterface

// File: rtl/conv_mac_relu_acc.sv
// Saturating bias+TAPS product accumulator with round-half-up rescale, ReLU and
// activation clamp, feeding a single-entry valid/ready output register.
//
//   state  | meaning
//   S_IDLE | no partial sum held; next accept is tap 0 and samples bias_din
//   S_ACC  | partial sum in acc, tap_cnt taps already taken
`timescale 1ns/1ps
module conv_mac_relu_acc #(
  parameter  int PROD_WIDTH = 24,
  parameter  int ACC_WIDTH  = 32,
  parameter  int OUT_WIDTH  = 14,
  parameter  int TAPS       = 9,
  parameter  int SHIFT      = 10,
  localparam int TW         = $clog2(TAPS + 1)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   clr,
  output logic [TW-1:0]          tap_cnt,
  conv_mac_relu_acc_if.slave     bus
);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [ACC_WIDTH:0] OMAX = {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc, acc_nxt, base, sum_sat;
  logic [ACC_WIDTH:0]     sum, rnd, shr;
  logic [OUT_WIDTH-1:0]   act, dout_q;
  logic [TW-1:0]          tap_nxt;
  logic                   valid_q, accept, first, last, load;

  assign bus.prod_ready = ~clr & (~valid_q | bus.out_ready);
  assign bus.out_dout   = dout_q;
  assign bus.out_valid  = valid_q;

  assign accept = bus.prod_valid & bus.prod_ready;
  assign first  = (state == S_IDLE);
  assign last   = first ? (TAPS == 1) : (tap_cnt == TW'(TAPS - 1));
  assign base   = first ? bus.bias_din : acc;

  // One guard bit catches the overflow before clamping to the accumulator range.
  assign sum = {base[ACC_WIDTH-1], base}
             + {{(ACC_WIDTH + 1 - PROD_WIDTH){bus.prod_din[PROD_WIDTH-1]}}, bus.prod_din};

  always_comb begin
    sum_sat = sum[ACC_WIDTH-1:0];
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
      sum_sat = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
  end

  // Saturated sum cannot exceed 2^31-1, so adding the half-LSB never overflows 33 bits.
  assign rnd = {sum_sat[ACC_WIDTH-1], sum_sat} + HALF;
  assign shr = $signed(rnd) >>> SHIFT;

  always_comb begin
    act = shr[OUT_WIDTH-1:0];
    if (shr[ACC_WIDTH] || (shr == '0))
      act = '0;
    else if (shr > OMAX)
      act = OMAX[OUT_WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    tap_nxt   = tap_cnt;
    load      = 1'b0;
    if (clr) begin
      state_nxt = S_IDLE;
      acc_nxt   = '0;
      tap_nxt   = '0;
    end else if (accept) begin
      if (last) begin
        load      = 1'b1;
        state_nxt = S_IDLE;
        acc_nxt   = '0;
        tap_nxt   = '0;
      end else begin
        state_nxt = S_ACC;
        acc_nxt   = sum_sat;
        tap_nxt   = tap_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      tap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      tap_cnt <= tap_nxt;
    end
  end

  // A load can only happen when the register is empty or draining, so no result is lost.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      dout_q  <= act;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule
